vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Generates 640x480@60 VGA timing from the system clock: pixel-enable divider, horizontal/vertical
//  counters, HSYNC/VSYNC, active-video flag and a frame tick. Counters feed the pattern/game pixel
//  generator; its combinational RGB332 result returns on rgb_in. That RGB is registered and blanked
//  here, aligned with the sync outputs, and drives the DAC pins.
// PARAMETERS
//  CLK_DIV   2    clk cycles per pixel (1 = pix_en tied high); 50 MHz / 2 = 25 MHz pixel rate
//  H_ACTIVE  640  visible pixels/line
//  H_FP      16   horizontal front porch
//  H_SYNC    96   horizontal sync width
//  H_BP      48   horizontal back porch (H_TOTAL = 800)
//  V_ACTIVE  480  visible lines/frame
//  V_FP      10   vertical front porch
//  V_SYNC    2    vertical sync width
//  V_BP      33   vertical back porch (V_TOTAL = 525)
//  HS_POL    0    HSYNC active level
//  VS_POL    0    VSYNC active level
// PORTS
//  clk       in   1   system clock
//  reset     in   1   asynchronous, active-high
//  pix_en    out  1   one-clk strobe per pixel; all counter/output updates qualify on it
//  h_count   out  10  current column, 0..H_TOTAL-1 (to pixel generator)
//  v_count   out  10  current line, 0..V_TOTAL-1 (to pixel generator)
//  video_on  out  1   (h_count < H_ACTIVE) && (v_count < V_ACTIVE), combinational from counters
//  frame_tick out 1   one-clk pulse on the pix_en where counters wrap (799,524)->(0,0)
//  rgb_in    in   8   RGB332 from pixel generator for current (h_count, v_count)
//  vga_rgb   out  8   registered, blanked RGB332 to DAC
//  vga_hs    out  1   registered HSYNC
//  vga_vs    out  1   registered VSYNC
// BEHAVIOUR
//  - Reset: div_cnt=0, h_count=0, v_count=0, pix_en=0, frame_tick=0, vga_rgb=0, vga_hs=~HS_POL,
//    vga_vs=~VS_POL. Reset asserted mid-frame clears immediately; after release, first pixel is (0,0).
//  - Divider: div_cnt counts 0..CLK_DIV-1, wraps; pix_en=1 when div_cnt==CLK_DIV-1 (registered strobe).
//  - On pix_en: h_count==H_TOTAL-1 -> h_count=0 and v_count advances (V_TOTAL-1 -> 0); else h_count+1.
//    No update on clocks without pix_en. Counters never exceed TOTAL-1.
//  - Sync windows (decoded from the pre-register counter values):
//    hs_act = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751]
//    vs_act = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]
//  - Output stage, on pix_en: vga_rgb <= video_on ? rgb_in : 0; vga_hs <= hs_act ? HS_POL : ~HS_POL;
//    vga_vs likewise. RGB, HS and VS share one pixel of latency, so the pins stay mutually aligned.
//    rgb_in is sampled in the same pixel slot its counters were presented.
//  - frame_tick = pix_en && h_count==H_TOTAL-1 && v_count==V_TOTAL-1, registered so it pulses the
//    clk after that pixel; exactly one pulse per 420000 pixels.
//  - Blanking: any non-zero rgb_in outside the active region never reaches vga_rgb.
//  - Width: counters 10 bit; elaboration error if H_TOTAL or V_TOTAL > 1024, or CLK_DIV < 1.
// STRUCTURE
//  - vga_timing_pkg: timing defaults, H_TOTAL/V_TOTAL derivations, RGB332 width, black constant.
//  - Sub-module vga_axis_counter (params TOTAL, SYNC_START, SYNC_LEN; ports clk, reset, inc,
//    count, wrap, sync_act), instantiated for horizontal (inc=pix_en) and vertical
//    (inc=pix_en && h wrap). Divider, video_on, frame_tick and output registers live in the top.
// TESTING
//  1 Reset held, then released -> h=v=0, vga_rgb=0, hs=vs=1; first pix_en 2 clks after release.
//  2 Free run one line, rgb_in=8'hFF -> vga_hs low for exactly 96 pixels starting h=656 (+1 pixel
//    latency); vga_rgb=FF for 640 pixels, 0 for 160.
//  3 Full frame -> vga_vs low for lines 490-491 only; frame_tick exactly once, at wrap (799,524)->(0,0).
//  4 Drive rgb_in=8'h1C during blanking (h=700, v=100 and h=10, v=500) -> vga_rgb stays 0.
//  5 Assert reset at (h=400, v=300) for 3 clks -> counters 0 immediately; next frame timing exact.
//  6 CLK_DIV=1 build -> pix_en constantly high after reset; line period 800 clks, frame 420000 clks.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared timing defaults for the VGA sync generator.
//   Holds the 640x480@60 porch/sync widths, the derived line/frame
//   totals, the counter width and the RGB332 pixel format constants.
package vga_timing_pkg;

  localparam int DEF_CLK_DIV  = 2;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic DEF_HS_POL = 1'b0;
  localparam logic DEF_VS_POL = 1'b0;

  localparam int CNT_W = 10;
  localparam int CNT_LIMIT = 1 << CNT_W;

  localparam int RGB_W = 8;
  localparam logic [RGB_W-1:0] RGB_BLACK = '0;

  // Total period of one axis: visible + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int DEF_H_TOTAL = axis_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int DEF_V_TOTAL = axis_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (horizontal or vertical).
//   Counts 0..TOTAL-1 on each inc strobe and wraps to 0.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   inc         advance the count by one this clock
//   count       current position on the axis
//   wrap        high while count is at TOTAL-1 (next inc wraps)
//   sync_act    high while count lies in [SYNC_START, SYNC_START+SYNC_LEN-1]
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             sync_act
);

  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] SYNC_FIRST = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(SYNC_START + SYNC_LEN - 1);

  assign wrap     = (count == LAST);
  assign sync_act = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA timing generator with registered, blanked RGB output.
//   A clock divider produces a one-clk pix_en strobe per pixel; horizontal
//   and vertical axis counters advance on it. The pixel generator reads
//   h_count/v_count and returns RGB332 on rgb_in in the same pixel slot.
//   RGB, HSYNC and VSYNC are registered together on pix_en so the DAC
//   pins stay mutually aligned (one pixel behind the counters).
// Ports:
//   clk, reset  system clock, asynchronous active-high reset
//   pix_en      one-clk strobe per pixel
//   h_count     current column, 0..H_TOTAL-1
//   v_count     current line, 0..V_TOTAL-1
//   video_on    counters are inside the visible area (combinational)
//   frame_tick  one-clk pulse after the last pixel of a frame
//   rgb_in      RGB332 for the current (h_count, v_count)
//   vga_rgb     registered RGB332, forced black outside the visible area
//   vga_hs      registered HSYNC
//   vga_vs      registered VSYNC
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV  = DEF_CLK_DIV,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             video_on,
  output logic             frame_tick,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] vga_rgb,
  output logic             vga_hs,
  output logic             vga_vs
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (H_TOTAL > CNT_LIMIT || V_TOTAL > CNT_LIMIT || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_gen: totals must fit 10-bit counters and CLK_DIV must be >= 1");
  end

  // A one-bit divider is kept for CLK_DIV=1; it simply stays at 0 so
  // pix_en is high on every clock after reset.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      pix_en  <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
    end
  end

  logic h_wrap;
  logic v_wrap;
  logic hs_act;
  logic vs_act;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC)
  ) u_h_axis (
    .clk      (clk),
    .reset    (reset),
    .inc      (pix_en),
    .count    (h_count),
    .wrap     (h_wrap),
    .sync_act (hs_act)
  );

  // The line counter steps only on the pixel that ends a line.
  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC)
  ) u_v_axis (
    .clk      (clk),
    .reset    (reset),
    .inc      (pix_en && h_wrap),
    .count    (v_count),
    .wrap     (v_wrap),
    .sync_act (vs_act)
  );

  assign video_on = (h_count < CNT_W'(H_ACTIVE)) && (v_count < CNT_W'(V_ACTIVE));

  // Output stage: everything here is decoded from the counter values of
  // the pixel being presented, so all pins carry the same one-pixel delay.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_rgb    <= RGB_BLACK;
      vga_hs     <= ~HS_POL;
      vga_vs     <= ~VS_POL;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_en && h_wrap && v_wrap;
      if (pix_en) begin
        vga_rgb <= video_on ? rgb_in : RGB_BLACK;
        vga_hs  <= hs_act ? HS_POL : ~HS_POL;
        vga_vs  <= vs_act ? VS_POL : ~VS_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed bench for vga_sync_gen.
//   Three instances: default 640x480 timing (CLK_DIV=2), a reduced 16x12
//   timing (CLK_DIV=2) so whole frames fit in a short run, and the same
//   reduced timing with CLK_DIV=1. A selector routes one instance's
//   outputs to the checking code.
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  typedef struct {
    int s;
    int p;
    int h;
    int v;
    int vid;
    int rgb;
    int hs;
    int vs;
  } vec_t;

  // Reduced timing: H 8+2+3+3 = 16, V 6+2+2+2 = 12
  localparam int SH_ACT = 8;
  localparam int SH_FP = 2;
  localparam int SH_SYNC = 3;
  localparam int SH_BP = 3;
  localparam int SV_ACT = 6;
  localparam int SV_FP = 2;
  localparam int SV_SYNC = 2;
  localparam int SV_BP = 2;

  // Hand-derived per-instance timing used by the reference model
  int p_ht[3]  = '{800, 16, 16};
  int p_vt[3]  = '{525, 12, 12};
  int p_ha[3]  = '{640, 8, 8};
  int p_va[3]  = '{480, 6, 6};
  int p_hs0[3] = '{656, 10, 10};
  int p_hs1[3] = '{751, 12, 12};
  int p_vs0[3] = '{490, 8, 8};
  int p_vs1[3] = '{491, 9, 9};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   rel = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rgb0 = 8'h00;
  logic [7:0] rgb1 = 8'h00;
  logic [7:0] rgb2 = 8'h00;

  logic       pe0, pe1, pe2, vo0, vo1, vo2, ft0, ft1, ft2;
  logic       hs0, hs1, hs2, vs0, vs1, vs2;
  logic [9:0] h0, h1, h2, v0, v1, v2;
  logic [7:0] ro0, ro1, ro2;

  vga_sync_gen u_dut (
    .clk(clk), .reset(reset), .pix_en(pe0), .h_count(h0), .v_count(v0),
    .video_on(vo0), .frame_tick(ft0), .rgb_in(rgb0), .vga_rgb(ro0),
    .vga_hs(hs0), .vga_vs(vs0)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_small (
    .clk(clk), .reset(reset), .pix_en(pe1), .h_count(h1), .v_count(v1),
    .video_on(vo1), .frame_tick(ft1), .rgb_in(rgb1), .vga_rgb(ro1),
    .vga_hs(hs1), .vga_vs(vs1)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_ACTIVE(SH_ACT), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
    .V_ACTIVE(SV_ACT), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
  ) u_fast (
    .clk(clk), .reset(reset), .pix_en(pe2), .h_count(h2), .v_count(v2),
    .video_on(vo2), .frame_tick(ft2), .rgb_in(rgb2), .vga_rgb(ro2),
    .vga_hs(hs2), .vga_vs(vs2)
  );

  // ---------------- instance selector ----------------
  int         sel = 0;
  logic       s_pe, s_vo, s_ft, s_hs, s_vs;
  logic [9:0] s_h, s_v;
  logic [7:0] s_rgb;

  always_comb begin
    s_pe = pe0; s_vo = vo0; s_ft = ft0; s_hs = hs0; s_vs = vs0;
    s_h = h0; s_v = v0; s_rgb = ro0;
    case (sel)
      1: begin
        s_pe = pe1; s_vo = vo1; s_ft = ft1; s_hs = hs1; s_vs = vs1;
        s_h = h1; s_v = v1; s_rgb = ro1;
      end
      2: begin
        s_pe = pe2; s_vo = vo2; s_ft = ft2; s_hs = hs2; s_vs = vs2;
        s_h = h2; s_v = v2; s_rgb = ro2;
      end
      default: ;
    endcase
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int slot = -1;
  bit stalled = 1'b0;
  int tick_n = 0, tick1 = 0, tick2 = 0, idle_n = 0;
  int bad_cnt = 0, bad_out = 0;
  int hs_low_n = 0, hs_first = -1, vs_low_n = 0, vs_first = -1, rgb_on_n = 0;
  logic [9:0] exp_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_h(input int s, input int p);
    return p % p_ht[s];
  endfunction

  function automatic int m_v(input int s, input int p);
    return (p / p_ht[s]) % p_vt[s];
  endfunction

  function automatic int m_vid(input int s, input int p);
    return (m_h(s, p) < p_ha[s] && m_v(s, p) < p_va[s]) ? 1 : 0;
  endfunction

  // {rgb, hs, vs} expected on the pins one pixel after pixel p
  function automatic logic [9:0] m_out(input int s, input int p, input logic [7:0] rgb);
    logic hs_n, vs_n;
    hs_n = !(m_h(s, p) >= p_hs0[s] && m_h(s, p) <= p_hs1[s]);
    vs_n = !(m_v(s, p) >= p_vs0[s] && m_v(s, p) <= p_vs1[s]);
    return {(m_vid(s, p) != 0) ? rgb : 8'h00, hs_n, vs_n};
  endfunction

  function automatic logic [7:0] pat(input int mode, input int p);
    case (mode)
      0: return 8'hFF;
      1: return 8'h1C;
      default: return 8'(p * 37 + 5);
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_rgb(input int s, input logic [7:0] val);
    case (s)
      0: rgb0 = val;
      1: rgb1 = val;
      default: rgb2 = val;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    slot = -1;
    tick_n = 0; tick1 = 0; tick2 = 0; idle_n = 0;
  endtask

  // Advance to the next negedge where pix_en is high (bounded).
  task automatic next_slot(output bit ok);
    int k;
    ok = 1'b0;
    k = 0;
    while (!ok && k < 4) begin
      @(negedge clk);
      k++;
      if (s_ft) begin
        tick_n++;
        if (tick_n == 1) tick1 = cyc - rel;
        else if (tick_n == 2) tick2 = cyc - rel;
      end
      if (s_pe) begin
        ok = 1'b1;
        slot++;
      end else begin
        idle_n++;
      end
    end
    if (!ok) begin
      stalled = 1'b1;
      check("pix_en_timeout", 0, 1);
    end
  endtask

  task automatic walk_to(input int target);
    bit ok;
    ok = 1'b1;
    while (ok && !stalled && slot < target) next_slot(ok);
  endtask

  // Run n pixel slots from just after reset release, driving rgb_in from
  // the pattern and scoring counters and pins against the model.
  task automatic run(input int s, input int mode, input int n);
    bit ok;
    logic [9:0] e;
    logic [7:0] val;
    bad_cnt = 0; bad_out = 0;
    hs_low_n = 0; hs_first = -1; vs_low_n = 0; vs_first = -1; rgb_on_n = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      if (stalled) break;
      next_slot(ok);
      if (!ok) break;
      if (int'(s_h) != m_h(s, slot) || int'(s_v) != m_v(s, slot) ||
          int'(s_vo) != m_vid(s, slot)) bad_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if ({s_rgb, s_hs, s_vs} !== e) bad_out++;
        if (!s_hs) begin
          hs_low_n++;
          if (hs_first < 0) hs_first = slot - 1;
        end
        if (!s_vs) begin
          vs_low_n++;
          if (vs_first < 0) vs_first = slot - 1;
        end
        if (s_rgb != 8'h00) rgb_on_n++;
      end
      val = pat(mode, slot);
      drive_rgb(s, val);
      exp_q.push_back(m_out(s, slot, val));
    end
  endtask

  function automatic vec_t mk(input int s, input int p, input int h, input int v,
                              input int vid, input int rgb, input int hs, input int vs);
    vec_t r;
    r.s = s; r.p = p; r.h = h; r.v = v; r.vid = vid; r.rgb = rgb; r.hs = hs; r.vs = vs;
    return r;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #3ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int cur;

    // Vectors: at pixel slot p -> counters of pixel p, pins of pixel p-1.
    // Instance 0 drives rgb_in=FF, instance 1 drives rgb_in=1C.
    vecs.push_back(mk(0,   1,   1, 0, 1, 'hFF, 1, 1));
    vecs.push_back(mk(0, 640, 640, 0, 0, 'hFF, 1, 1));
    vecs.push_back(mk(0, 641, 641, 0, 0, 'h00, 1, 1));
    vecs.push_back(mk(0, 656, 656, 0, 0, 'h00, 1, 1));
    vecs.push_back(mk(0, 657, 657, 0, 0, 'h00, 0, 1));
    vecs.push_back(mk(0, 752, 752, 0, 0, 'h00, 0, 1));
    vecs.push_back(mk(0, 753, 753, 0, 0, 'h00, 1, 1));
    vecs.push_back(mk(0, 800,   0, 1, 1, 'h00, 1, 1));
    vecs.push_back(mk(0, 801,   1, 1, 1, 'hFF, 1, 1));
    vecs.push_back(mk(1,   1,  1,  0, 1, 'h1C, 1, 1));
    vecs.push_back(mk(1,   2,  2,  0, 1, 'h1C, 1, 1));
    vecs.push_back(mk(1,   9,  9,  0, 0, 'h00, 1, 1));
    vecs.push_back(mk(1,  11, 11,  0, 0, 'h00, 0, 1));
    vecs.push_back(mk(1,  13, 13,  0, 0, 'h00, 0, 1));
    vecs.push_back(mk(1,  14, 14,  0, 0, 'h00, 1, 1));
    vecs.push_back(mk(1,  24,  8,  1, 0, 'h1C, 1, 1));
    vecs.push_back(mk(1,  96,  0,  6, 0, 'h00, 1, 1));
    vecs.push_back(mk(1,  97,  1,  6, 0, 'h00, 1, 1));
    vecs.push_back(mk(1, 129,  1,  8, 0, 'h00, 1, 0));
    vecs.push_back(mk(1, 145,  1,  9, 0, 'h00, 1, 0));
    vecs.push_back(mk(1, 161,  1, 10, 0, 'h00, 1, 1));
    vecs.push_back(mk(1, 192,  0,  0, 1, 'h00, 1, 1));
    vecs.push_back(mk(1, 193,  1,  0, 1, 'h1C, 1, 1));

    // Reset held, then released
    sel = 0;
    repeat (4) @(negedge clk);
    check("rst_h", int'(s_h), 0);
    check("rst_v", int'(s_v), 0);
    check("rst_rgb", int'(s_rgb), 0);
    check("rst_hs", int'(s_hs), 1);
    check("rst_vs", int'(s_vs), 1);
    check("rst_pe", int'(s_pe), 0);
    check("rst_ft", int'(s_ft), 0);
    reset = 1'b0;
    @(negedge clk);
    check("pe_clk1", int'(s_pe), 0);
    @(negedge clk);
    check("pe_clk2", int'(s_pe), 1);
    check("first_h", int'(s_h), 0);
    check("first_v", int'(s_v), 0);

    // Table-driven vectors
    cur = -1;
    foreach (vecs[i]) begin
      if (vecs[i].s != cur || vecs[i].p <= slot) begin
        sel = vecs[i].s;
        rgb0 = 8'hFF; rgb1 = 8'h1C; rgb2 = 8'h00;
        do_reset();
        cur = vecs[i].s;
      end
      walk_to(vecs[i].p);
      check($sformatf("vec%0d_h", i), int'(s_h), vecs[i].h);
      check($sformatf("vec%0d_v", i), int'(s_v), vecs[i].v);
      check($sformatf("vec%0d_vid", i), int'(s_vo), vecs[i].vid);
      check($sformatf("vec%0d_rgb", i), int'(s_rgb), vecs[i].rgb);
      check($sformatf("vec%0d_hs", i), int'(s_hs), vecs[i].hs);
      check($sformatf("vec%0d_vs", i), int'(s_vs), vecs[i].vs);
    end

    // One full default line with rgb_in=FF
    sel = 0;
    do_reset();
    run(0, 0, 801);
    check("line_cnt_bad", bad_cnt, 0);
    check("line_out_bad", bad_out, 0);
    check("line_hs_low_n", hs_low_n, 96);
    check("line_hs_first", hs_first, 656);
    check("line_rgb_on_n", rgb_on_n, 640);
    check("line_vs_low_n", vs_low_n, 0);
    check("line_ticks", tick_n, 0);

    // Two reduced frames, scrambled rgb_in (blanking included)
    sel = 1;
    do_reset();
    run(1, 2, 385);
    check("frm_cnt_bad", bad_cnt, 0);
    check("frm_out_bad", bad_out, 0);
    check("frm_hs_low_n", hs_low_n, 72);
    check("frm_vs_low_n", vs_low_n, 64);
    check("frm_vs_first", vs_first, 128);
    check("frm_ticks", tick_n, 2);
    check("frm_tick1_clk", tick1, 385);
    check("frm_tick2_clk", tick2, 769);

    // Reset asserted mid-frame at (h=4, v=3)
    do_reset();
    run(1, 2, 53);
    check("mid_h", int'(s_h), 4);
    check("mid_v", int'(s_v), 3);
    reset = 1'b1;
    #1;
    check("mid_rst_h", int'(s_h), 0);
    check("mid_rst_v", int'(s_v), 0);
    check("mid_rst_pe", int'(s_pe), 0);
    check("mid_rst_rgb", int'(s_rgb), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rel = cyc;
    slot = -1;
    tick_n = 0; tick1 = 0; tick2 = 0; idle_n = 0;
    run(1, 2, 193);
    check("post_cnt_bad", bad_cnt, 0);
    check("post_out_bad", bad_out, 0);
    check("post_ticks", tick_n, 1);
    check("post_tick1_clk", tick1, 385);

    // CLK_DIV=1: pix_en every clock, frame of 192 clocks
    sel = 2;
    do_reset();
    run(2, 2, 385);
    check("div1_idle", idle_n, 0);
    check("div1_last_clk", cyc - rel, 385);
    check("div1_cnt_bad", bad_cnt, 0);
    check("div1_out_bad", bad_out, 0);
    check("div1_ticks", tick_n, 2);
    check("div1_tick1_clk", tick1, 193);
    check("div1_tick2_clk", tick2, 385);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
